wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 es_to_ws_valid  in  2  bit0 = instruction present; bit1 = instruction complete and ready to retire.
REQ-004 es_to_ws_bus  in  `ES_TO_WS_BUS_WD (117)  {csr_wen, csr_addr[13:0], csr_wdata[31:0], gr_we, dest[4:0], result[31:0], pc[31:0]}, MSB first.
REQ-005 ws_ready  out  1  high when the stage accepts an entry this cycle.
REQ-006 rf_grant  in  1  shared regfile write port granted to this pipe this cycle.
REQ-007 rf_we / rf_waddr / rf_wdata  out  1/5/32  regfile write port.
REQ-008 csr_we / csr_waddr / csr_wdata  out  1/14/32  CSR write port.
REQ-009 forward_data1 / forward_data2  out  `FORWAED_BUS_WD (86) each  {valid[85], csr_wen[84], csr_addr[83:70], csr_wdata[69:38], gr_we[37], dest[36:32], data[31:0]}; data1 = head (older) entry, data2 = tail (younger) entry.
REQ-010 retire_valid / retire_pc  out  1/32  one instruction committed this cycle, with its pc.

Function
REQ-011 Buffer: 2-entry in-order FIFO (head, tail) with 2-bit occupancy count 0..2.
REQ-012 Push when es_to_ws_valid[1] and ws_ready; valid = 2'b01 (present, not complete) is never pushed.
REQ-013 ws_ready = (count != 2); depends only on registered state, no path from rf_grant or the inputs.
REQ-014 Pop when count != 0 and rf_grant; a popped entry is the retired instruction of that cycle.
REQ-015 Latency: an entry accepted at edge N is written to the regfile/CSR no earlier than cycle N+1; there is no combinational bypass from inputs to write ports.
REQ-016 rf_we = pop and gr_we and dest != 0; rf_waddr = dest; rf_wdata = result.
REQ-017 csr_we = pop and csr_wen; csr_waddr = csr_addr; csr_wdata = csr_wdata field.
REQ-018 retire_valid = pop; retire_pc = head pc; retire_pc = 0 when retire_valid = 0.
REQ-019 forward_data1.valid = (count >= 1); forward_data2.valid = (count == 2); the fields of an invalid forward bus are driven 0.
REQ-020 Forward gr_we bit = gr_we and dest != 0; consumers give forward_data2 priority over forward_data1 for register data.
REQ-021 Simultaneous push and pop: at count 1, the count stays 1 and the incoming entry becomes head; at count 2, push is blocked by ws_ready = 0 and the pop gives count 1.
REQ-022 Full with rf_grant = 0: contents hold, no write-port activity, and ws_ready = 0 until a pop occurs.
REQ-023 Empty with rf_grant = 1: no pop, and all write-port outputs are 0.
REQ-024 The stage has no flush input; entries that are accepted are committed in order.

Reset
REQ-025 resetn low: count = 0 and entry valid bits = 0, immediately and independent of clk.
REQ-026 During reset, ws_ready, rf_we, csr_we, retire_valid and both forward valid bits are 0, and all data outputs are 0.
REQ-027 Reset mid-operation discards buffered entries without writing them.
REQ-028 ws_ready = 1 from the first rising edge after resetn deasserts.

Configuration
REQ-029 DIFFTEST_EN defined: input ds_debug_in [`ES_WS_DEBUG_BUS_WD] is pushed and popped with each entry.
REQ-030 DIFFTEST_EN defined: output ws_debug_out carries the popped entry's debug word, and is 0 when retire_valid = 0 and during reset.
REQ-031 DIFFTEST_EN undefined: the debug ports and debug storage are absent; all other behaviour is identical.

Verification
REQ-032 Single write: push {gr_we=1, dest=5, result=0xDEADBEEF, pc=0x1C000000} with rf_grant=1 -> the next cycle gives rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, retire_pc=0x1C000000.
REQ-033 r0 suppression: push dest=0, gr_we=1 -> retire_valid=1, rf_we=0, and forward_data1[37]=0.
REQ-034 Backpressure: rf_grant=0 while pushing A then B -> count=2 and ws_ready=0, with forward_data1=A and forward_data2=B; rf_grant=1 -> A retires, ws_ready=1, then B retires.
REQ-035 Incomplete input: es_to_ws_valid=2'b01 for 3 cycles -> count stays 0 and no write occurs.
REQ-036 CSR write: push {csr_wen=1, csr_addr=0x0006, csr_wdata=0x12345678} -> csr_we=1 with the same address and data on retire, and forward_data1[84]=1 while the entry is buffered.
REQ-037 Async reset: assert resetn=0 mid-cycle with 2 entries buffered -> all outputs go to 0 before the next edge, and neither entry is written after release.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: write-back stage with a 2-entry in-order retire buffer in front of a shared regfile/CSR write port.
// Optional DIFFTEST_EN carries a per-entry debug word through the buffer to ws_debug_out.
`ifndef ES_TO_WS_BUS_WD
`define ES_TO_WS_BUS_WD 117
`endif
`ifndef FORWAED_BUS_WD
`define FORWAED_BUS_WD 86
`endif
`ifndef ES_WS_DEBUG_BUS_WD
`define ES_WS_DEBUG_BUS_WD 64
`endif

module wb_stage (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [1:0]                   es_to_ws_valid,
  input  logic [`ES_TO_WS_BUS_WD-1:0]  es_to_ws_bus,
  output logic                         ws_ready,
  input  logic                         rf_grant,
  output logic                         rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [31:0]                  rf_wdata,
  output logic                         csr_we,
  output logic [13:0]                  csr_waddr,
  output logic [31:0]                  csr_wdata,
  output logic [`FORWAED_BUS_WD-1:0]   forward_data1,
  output logic [`FORWAED_BUS_WD-1:0]   forward_data2,
  output logic                         retire_valid,
  output logic [31:0]                  retire_pc
`ifdef DIFFTEST_EN
  ,
  input  logic [`ES_WS_DEBUG_BUS_WD-1:0] ds_debug_in,
  output logic [`ES_WS_DEBUG_BUS_WD-1:0] ws_debug_out
`endif
);

  typedef struct packed {
    logic        csr_wen;
    logic [13:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } entry_t;

  // Forward bus image of one entry; an invalid slot is all zeros so consumers can OR-free mux.
  function automatic logic [`FORWAED_BUS_WD-1:0] fwd_pack(input logic v, input entry_t e);
    logic [`FORWAED_BUS_WD-1:0] f;
    f = '0;
    if (v) begin
      f = {1'b1, e.csr_wen, e.csr_addr, e.csr_wdata,
           e.gr_we && (e.dest != 5'd0), e.dest, e.result};
    end
    return f;
  endfunction

  logic [1:0] count_q, count_d;
  logic       rdy_q;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  entry_t     in_ent;
  logic       push, pop;
  logic [1:0] slot;

`ifdef DIFFTEST_EN
  logic [`ES_WS_DEBUG_BUS_WD-1:0] dbg_head_q, dbg_head_d;
  logic [`ES_WS_DEBUG_BUS_WD-1:0] dbg_tail_q, dbg_tail_d;
`endif

  // ---- stage 0: accept / retire decision from registered occupancy ----
  always_comb begin
    in_ent   = entry_t'(es_to_ws_bus);
    ws_ready = rdy_q && (count_q != 2'd2);
    push     = es_to_ws_valid[1] && ws_ready;
    pop      = (count_q != 2'd0) && rf_grant;
    // Slot the incoming entry lands in after any same-cycle pop has shifted the buffer.
    slot     = count_q - {1'b0, pop};
    count_d  = count_q + {1'b0, push} - {1'b0, pop};

    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      head_d = tail_q;
    end
    if (push) begin
      if (slot == 2'd0) begin
        head_d = in_ent;
      end else begin
        tail_d = in_ent;
      end
    end

`ifdef DIFFTEST_EN
    dbg_head_d = dbg_head_q;
    dbg_tail_d = dbg_tail_q;
    if (pop) begin
      dbg_head_d = dbg_tail_q;
    end
    if (push) begin
      if (slot == 2'd0) begin
        dbg_head_d = ds_debug_in;
      end else begin
        dbg_tail_d = ds_debug_in;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= 2'd0;
      rdy_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      rdy_q   <= 1'b1;
    end
  end

  // Payload storage carries no reset; occupancy gates every use of it.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
`ifdef DIFFTEST_EN
    dbg_head_q <= dbg_head_d;
    dbg_tail_q <= dbg_tail_d;
`endif
  end

  // ---- stage 1: write ports and forwarding from buffered state ----
  always_comb begin
    rf_we         = pop && head_q.gr_we && (head_q.dest != 5'd0);
    rf_waddr      = pop ? head_q.dest   : 5'd0;
    rf_wdata      = pop ? head_q.result : 32'd0;
    csr_we        = pop && head_q.csr_wen;
    csr_waddr     = pop ? head_q.csr_addr  : 14'd0;
    csr_wdata     = pop ? head_q.csr_wdata : 32'd0;
    retire_valid  = pop;
    retire_pc     = pop ? head_q.pc : 32'd0;
    forward_data1 = fwd_pack(count_q != 2'd0, head_q);
    forward_data2 = fwd_pack(count_q == 2'd2, tail_q);
`ifdef DIFFTEST_EN
    ws_debug_out  = pop ? dbg_head_q : '0;
`endif
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic against a queue model.
`ifndef ES_TO_WS_BUS_WD
`define ES_TO_WS_BUS_WD 117
`endif
`ifndef FORWAED_BUS_WD
`define FORWAED_BUS_WD 86
`endif
`ifndef ES_WS_DEBUG_BUS_WD
`define ES_WS_DEBUG_BUS_WD 64
`endif

module tb_wb_stage;
  typedef struct packed {
    logic        csr_wen;
    logic [13:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        resetn;
  logic [1:0]                  es_to_ws_valid;
  logic [`ES_TO_WS_BUS_WD-1:0] es_to_ws_bus;
  logic                        ws_ready;
  logic                        rf_grant;
  logic                        rf_we;
  logic [4:0]                  rf_waddr;
  logic [31:0]                 rf_wdata;
  logic                        csr_we;
  logic [13:0]                 csr_waddr;
  logic [31:0]                 csr_wdata;
  logic [`FORWAED_BUS_WD-1:0]  forward_data1, forward_data2;
  logic                        retire_valid;
  logic [31:0]                 retire_pc;
`ifdef DIFFTEST_EN
  logic [`ES_WS_DEBUG_BUS_WD-1:0] dbg_in, dbg_out;
  logic [`ES_WS_DEBUG_BUS_WD-1:0] dq[$];
  logic [`ES_WS_DEBUG_BUS_WD-1:0] e_dbg;
`endif

  wb_stage dut (
    .clk(clk), .resetn(resetn), .es_to_ws_valid(es_to_ws_valid), .es_to_ws_bus(es_to_ws_bus),
    .ws_ready(ws_ready), .rf_grant(rf_grant), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .forward_data1(forward_data1), .forward_data2(forward_data2),
    .retire_valid(retire_valid), .retire_pc(retire_pc)
`ifdef DIFFTEST_EN
    , .ds_debug_in(dbg_in), .ws_debug_out(dbg_out)
`endif
  );

  localparam int OW = 1 + 1 + 5 + 32 + 1 + 14 + 32 + 1 + 32 + 2 * `FORWAED_BUS_WD;
  logic [OW-1:0] obs, exp_all;
  assign obs = {ws_ready, rf_we, rf_waddr, rf_wdata, csr_we, csr_waddr, csr_wdata,
                retire_valid, retire_pc, forward_data1, forward_data2};

  ent_t q[$];
  bit   alive;
  int   total = 0;
  int   bad = 0;

  function automatic ent_t mk(input logic cw, input logic [13:0] ca, input logic [31:0] cd,
                              input logic gw, input logic [4:0] d, input logic [31:0] r,
                              input logic [31:0] p);
    ent_t e;
    e.csr_wen = cw; e.csr_addr = ca; e.csr_wdata = cd;
    e.gr_we = gw; e.dest = d; e.result = r; e.pc = p;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e = mk(1'($urandom), 14'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom, $urandom);
    if ($urandom_range(0, 3) == 0) e.dest = 5'd0;
    return e;
  endfunction

  function automatic logic [`FORWAED_BUS_WD-1:0] fwd(input ent_t e);
    return {1'b1, e.csr_wen, e.csr_addr, e.csr_wdata, e.gr_we && (e.dest != 5'd0), e.dest, e.result};
  endfunction

  task automatic drive(input logic [1:0] v, input ent_t b, input logic g);
    es_to_ws_valid = v;
    es_to_ws_bus   = b;
    rf_grant       = g;
`ifdef DIFFTEST_EN
    dbg_in = (`ES_WS_DEBUG_BUS_WD)'({$urandom, $urandom});
`endif
  endtask

  // Expected outputs for the current inputs and model contents.
  task automatic model_eval();
    ent_t h;
    bit po;
    logic [`FORWAED_BUS_WD-1:0] f1, f2;
    h  = '0;
    f1 = '0;
    f2 = '0;
    po = (q.size() > 0) && rf_grant;
    if (q.size() > 0) begin h = q[0]; f1 = fwd(q[0]); end
    if (q.size() == 2) f2 = fwd(q[1]);
    exp_all = {alive && (q.size() < 2), po && h.gr_we && (h.dest != 5'd0),
               po ? h.dest : 5'd0, po ? h.result : 32'd0,
               po && h.csr_wen, po ? h.csr_addr : 14'd0, po ? h.csr_wdata : 32'd0,
               po, po ? h.pc : 32'd0, f1, f2};
`ifdef DIFFTEST_EN
    e_dbg = (po && dq.size() > 0) ? dq[0] : '0;
`endif
  endtask

  task automatic tick();
    bit pu, po;
    pu = resetn && es_to_ws_valid[1] && alive && (q.size() < 2);
    po = resetn && (q.size() > 0) && rf_grant;
    @(posedge clk);
    if (po) begin
      void'(q.pop_front());
`ifdef DIFFTEST_EN
      void'(dq.pop_front());
`endif
    end
    if (pu) begin
      q.push_back(ent_t'(es_to_ws_bus));
`ifdef DIFFTEST_EN
      dq.push_back(dbg_in);
`endif
    end
    if (resetn) alive = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    alive  = 1'b0;
    drive(2'b11, rnd_ent(), 1'b1);
    @(negedge clk);
    #2;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
    @(negedge clk);
    resetn = 1'b1;
    drive(2'b00, '0, 1'b0);
    tick();
    #2;
    model_eval();
    total++;
    if (ws_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", ws_ready); end
    total++;
    if (obs !== exp_all) begin bad++; $display("FAIL idle_after_reset: got %h want %h", obs, exp_all); end
  endtask

  task automatic test_single_write();
    drive(2'b11, mk(1'b0, 14'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h1C000000), 1'b1);
    #2;
    model_eval();
    total++;
    if (retire_valid !== 1'b0 || rf_we !== 1'b0) begin
      bad++; $display("FAIL single_no_bypass: got rv=%b we=%b want 0 0", retire_valid, rf_we);
    end
    tick();
    drive(2'b00, '0, 1'b1);
    #2;
    total++;
    if ({rf_we, rf_waddr, rf_wdata, retire_pc} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'h1C000000}) begin
      bad++; $display("FAIL single_write: got %b %0d %h %h want 1 5 deadbeef 1c000000",
                      rf_we, rf_waddr, rf_wdata, retire_pc);
    end
    tick();
  endtask

  task automatic test_r0();
    drive(2'b11, mk(1'b0, 14'd0, 32'd0, 1'b1, 5'd0, 32'h55AA55AA, 32'h1C000040), 1'b0);
    tick();
    drive(2'b00, '0, 1'b0);
    #2;
    total++;
    if (forward_data1[85] !== 1'b1 || forward_data1[37] !== 1'b0) begin
      bad++; $display("FAIL r0_forward: got v=%b gr=%b want 1 0", forward_data1[85], forward_data1[37]);
    end
    rf_grant = 1'b1;
    #1;
    total++;
    if (retire_valid !== 1'b1 || rf_we !== 1'b0) begin
      bad++; $display("FAIL r0_write: got rv=%b we=%b want 1 0", retire_valid, rf_we);
    end
    tick();
  endtask

  task automatic test_backpressure();
    ent_t a, b;
    a = mk(1'b0, 14'd0, 32'd0, 1'b1, 5'd7, 32'h0000AAAA, 32'h1C000100);
    b = mk(1'b1, 14'd9, 32'hCAFE0001, 1'b1, 5'd8, 32'h0000BBBB, 32'h1C000104);
    drive(2'b11, a, 1'b0); tick();
    drive(2'b11, b, 1'b0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, rnd_ent(), 1'b0);
      #2;
      total++;
      if (ws_ready !== 1'b0 || forward_data1 !== fwd(a) || forward_data2 !== fwd(b)) begin
        bad++; $display("FAIL full_hold: got rdy=%b f1=%h f2=%h want 0 %h %h",
                        ws_ready, forward_data1, forward_data2, fwd(a), fwd(b));
      end
      total++;
      if ({rf_we, csr_we, retire_valid} !== 3'b000) begin
        bad++; $display("FAIL full_quiet: got %b want 000", {rf_we, csr_we, retire_valid});
      end
      tick();
    end
    drive(2'b00, '0, 1'b1);
    #2;
    total++;
    if (retire_pc !== a.pc || rf_wdata !== a.result) begin
      bad++; $display("FAIL bp_retire_a: got %h %h want %h %h", retire_pc, rf_wdata, a.pc, a.result);
    end
    tick();
    #2;
    total++;
    if (ws_ready !== 1'b1 || retire_pc !== b.pc || csr_we !== 1'b1) begin
      bad++; $display("FAIL bp_retire_b: got rdy=%b pc=%h csr=%b want 1 %h 1", ws_ready, retire_pc, csr_we, b.pc);
    end
    tick();
  endtask

  task automatic test_incomplete();
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, rnd_ent(), 1'b1);
      #2;
      model_eval();
      total++;
      if (forward_data1[85] !== 1'b0 || rf_we !== 1'b0 || retire_valid !== 1'b0 || obs !== exp_all) begin
        bad++; $display("FAIL incomplete: got %h want %h", obs, exp_all);
      end
      tick();
    end
  endtask

  task automatic test_csr();
    drive(2'b11, mk(1'b1, 14'h0006, 32'h12345678, 1'b0, 5'd3, 32'h0, 32'h1C000200), 1'b0);
    tick();
    drive(2'b00, '0, 1'b0);
    #2;
    total++;
    if (forward_data1[84] !== 1'b1 || forward_data1[83:70] !== 14'h0006) begin
      bad++; $display("FAIL csr_forward: got %b %h want 1 0006", forward_data1[84], forward_data1[83:70]);
    end
    rf_grant = 1'b1;
    #1;
    total++;
    if ({csr_we, csr_waddr, csr_wdata, rf_we} !== {1'b1, 14'h0006, 32'h12345678, 1'b0}) begin
      bad++; $display("FAIL csr_write: got %b %h %h rf=%b want 1 0006 12345678 0",
                      csr_we, csr_waddr, csr_wdata, rf_we);
    end
    tick();
  endtask

  task automatic test_push_pop_one();
    ent_t a, b;
    a = rnd_ent();
    b = rnd_ent();
    drive(2'b11, a, 1'b0); tick();
    drive(2'b11, b, 1'b1);
    #2;
    total++;
    if (retire_pc !== a.pc || ws_ready !== 1'b1) begin
      bad++; $display("FAIL pushpop_retire: got %h rdy=%b want %h 1", retire_pc, ws_ready, a.pc);
    end
    tick();
    drive(2'b00, '0, 1'b0);
    #2;
    total++;
    if (forward_data1 !== fwd(b) || forward_data2 !== '0) begin
      bad++; $display("FAIL pushpop_head: got %h %h want %h 0", forward_data1, forward_data2, fwd(b));
    end
    drive(2'b00, '0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), rnd_ent(), ($urandom_range(0, 9) < 6));
      #2;
      model_eval();
      total++;
      if (obs !== exp_all) begin
        bad++; $display("FAIL random_%0d: got %h want %h", i, obs, exp_all);
      end
`ifdef DIFFTEST_EN
      total++;
      if (dbg_out !== e_dbg) begin
        bad++; $display("FAIL debug_%0d: got %h want %h", i, dbg_out, e_dbg);
      end
`endif
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(2'b11, rnd_ent(), 1'b0); tick();
    drive(2'b11, rnd_ent(), 1'b0); tick();
    drive(2'b00, '0, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    q.delete();
`ifdef DIFFTEST_EN
    dq.delete();
`endif
    alive = 1'b0;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL async_reset_outputs: got %h want 0", obs); end
    @(negedge clk);
    resetn = 1'b1;
    #2;
    total++;
    if ({rf_we, csr_we, retire_valid} !== 3'b000) begin
      bad++; $display("FAIL async_release_nowrite: got %b want 000", {rf_we, csr_we, retire_valid});
    end
    tick();
    #2;
    model_eval();
    total++;
    if (obs !== exp_all || ws_ready !== 1'b1) begin
      bad++; $display("FAIL async_after_edge: got %h want %h", obs, exp_all);
    end
  endtask

  initial begin
    resetn = 1'b0;
    drive(2'b00, '0, 1'b0);
    test_reset();
    test_single_write();
    test_r0();
    test_backpressure();
    test_incomplete();
    test_csr();
    test_push_pop_one();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
